// File: rtl/hpdl1414_pkg.sv
// ============================================================================
//  Module      : hpdl1414_pkg
//  Description : Shared types, constants and the character-fold helper for
//                the HPDL1414 display write sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hpdl1414_pkg;

    localparam int         NUM_POS    = 16;
    localparam int         NUM_DISP   = 4;
    localparam logic [6:0] CHAR_BLANK = 7'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } hpdl_state_t;

    // The HPDL1414 font only covers 0x20-0x5F. Lowercase is shifted to
    // uppercase and control codes are shown as blanks.
    function automatic logic [6:0] fold_char(input logic [6:0] c);
        logic [6:0] r;
        r = c;
        if (c < 7'h20) begin
            r = CHAR_BLANK;
        end else if (c >= 7'h60) begin
            r = c - 7'h20;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hpdl1414_phase_timer.sv
// ============================================================================
//  Module      : hpdl1414_phase_timer
//  Description : Down-counter timing one write phase. Loading N-1 makes
//                o_done assert N cycles later (in the Nth cycle of the phase).
//  Ports       : clk, rst (async, active-high), i_load, i_load_val, o_done
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpdl1414_phase_timer #(
    parameter int WIDTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    output logic                  o_done
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/hpdl1414_writer.sv
// ============================================================================
//  Module      : hpdl1414_writer
//  Description : Write sequencer for a 4x HPDL1414 array (16 positions).
//                Character writes land in a shadow buffer with dirty bits;
//                a scan FSM replays dirty positions onto the display bus
//                with programmable setup / pulse / hold timing.
//  Ports       : CLK_i, RST_i (async, active-high)
//                in_valid, in_ready, in_pos[3:0], in_char[6:0]
//                HPDL_D[6:0], HPDL_A[1:0], HPDL_WR_n[3:0], busy
//  Options     : HPDL1414_CLEAR_ON_RESET_EN - mark all positions dirty at
//                reset so every display is blanked before normal service.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpdl1414_writer
    import hpdl1414_pkg::*;
#(
    parameter int SETUP_CYC = 1,   // must be >= 1
    parameter int PULSE_CYC = 2,   // must be >= 1
    parameter int HOLD_CYC  = 1    // must be >= 1
) (
    input  wire logic       CLK_i,
    input  wire logic       RST_i,
    input  wire logic       in_valid,
    output logic            in_ready,
    input  wire logic [3:0] in_pos,
    input  wire logic [6:0] in_char,
    output logic [6:0]      HPDL_D,
    output logic [1:0]      HPDL_A,
    output logic [3:0]      HPDL_WR_n,
    output logic            busy
);

    localparam int c_MAX_CYC = (SETUP_CYC > PULSE_CYC) ?
                               ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                               ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    // Timer holds values up to c_MAX_CYC-1.
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

`ifdef HPDL1414_CLEAR_ON_RESET_EN
    localparam logic [NUM_POS-1:0] c_DIRTY_RST = '1;
`else
    localparam logic [NUM_POS-1:0] c_DIRTY_RST = '0;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    hpdl_state_t         r_state;
    hpdl_state_t         w_state_next;
    logic [3:0]          r_scan;
    logic [NUM_POS-1:0]  r_dirty;
    logic [NUM_POS-1:0]  w_dirty_next;
    logic [6:0]          r_buf [NUM_POS];
    logic [6:0]          r_hpdl_d;
    logic [1:0]          r_hpdl_a;
    logic [3:0]          r_wr_n;
    logic                r_busy;
    logic                r_in_ready;

    logic                w_accept;
    logic                w_latch;
    logic                w_wr_assert;
    logic                w_wr_release;
    logic                w_scan_inc;
    logic                w_tmr_load;
    logic [c_CNT_W-1:0]  w_tmr_val;
    logic                w_tmr_done;

    assign w_accept = in_valid & r_in_ready;

    // ------------------------------------------------------------------
    // Phase timer
    // ------------------------------------------------------------------
    hpdl1414_phase_timer #(
        .WIDTH      (c_CNT_W)
    ) u_phase_timer (
        .clk        (CLK_i),
        .rst        (RST_i),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_wr_assert  = 1'b0;
        w_wr_release = 1'b0;
        w_scan_inc   = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_dirty[r_scan]) begin
                    w_latch      = 1'b1;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = c_CNT_W'(SETUP_CYC - 1);
                    w_state_next = ST_SETUP;
                end else begin
                    w_scan_inc   = 1'b1;
                end
            end
            ST_SETUP: begin
                if (w_tmr_done) begin
                    w_wr_assert  = 1'b1;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = c_CNT_W'(PULSE_CYC - 1);
                    w_state_next = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (w_tmr_done) begin
                    w_wr_release = 1'b1;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = c_CNT_W'(HOLD_CYC - 1);
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_tmr_done) begin
                    w_scan_inc   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Set is applied after clear so a write racing the IDLE latch of the
    // same position keeps it dirty for a later pass.
    always_comb begin
        w_dirty_next = r_dirty;
        if (w_latch) begin
            w_dirty_next[r_scan] = 1'b0;
        end
        if (w_accept) begin
            w_dirty_next[in_pos] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            r_scan     <= '0;
            r_dirty    <= c_DIRTY_RST;
            r_hpdl_d   <= '0;
            r_hpdl_a   <= '0;
            r_wr_n     <= 4'b1111;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
            for (int i = 0; i < NUM_POS; i++) begin
                r_buf[i] <= CHAR_BLANK;
            end
        end else begin
            r_in_ready <= 1'b1;
            r_dirty    <= w_dirty_next;
            r_busy     <= (|w_dirty_next) || (w_state_next != ST_IDLE);

            if (w_accept) begin
                r_buf[in_pos] <= fold_char(in_char);
            end

            // The buffer is read before this cycle's write lands, so a
            // same-cycle write to the scanned position is picked up on
            // the next pass through its dirty bit.
            if (w_latch) begin
                r_hpdl_d <= r_buf[r_scan];
                r_hpdl_a <= ~r_scan[1:0];
            end

            // scan is frozen during SETUP/PULSE/HOLD, so its upper bits
            // still select the display being strobed.
            if (w_wr_assert) begin
                r_wr_n <= ~(4'b0001 << r_scan[3:2]);
            end else if (w_wr_release) begin
                r_wr_n <= 4'b1111;
            end

            if (w_scan_inc) begin
                r_scan <= r_scan + 4'd1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign HPDL_D    = r_hpdl_d;
    assign HPDL_A    = r_hpdl_a;
    assign HPDL_WR_n = r_wr_n;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_hpdl1414_writer.sv
// ============================================================================
//  Module      : tb_hpdl1414_writer
//  Description : Scoreboard bench for hpdl1414_writer. The stimulus process
//                queues the expected strobe (WR_n, D, A) for every write;
//                the monitor pops on each WR_n falling edge and also checks
//                pulse width, one-hot strobe and D/A stability.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hpdl1414_writer;

    localparam int c_PULSE = 2;

    logic       CLK_i    = 1'b0;
    logic       RST_i    = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_pos   = 4'd0;
    logic [6:0] in_char  = 7'd0;
    logic       in_ready;
    logic [6:0] HPDL_D;
    logic [1:0] HPDL_A;
    logic [3:0] HPDL_WR_n;
    logic       busy;

    hpdl1414_writer #(
        .SETUP_CYC (1),
        .PULSE_CYC (c_PULSE),
        .HOLD_CYC  (1)
    ) dut (
        .CLK_i     (CLK_i),
        .RST_i     (RST_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pos    (in_pos),
        .in_char   (in_char),
        .HPDL_D    (HPDL_D),
        .HPDL_A    (HPDL_A),
        .HPDL_WR_n (HPDL_WR_n),
        .busy      (busy)
    );

    always #5 CLK_i = ~CLK_i;

    typedef struct packed {
        logic [3:0] wr_n;
        logic [6:0] d;
        logic [1:0] a;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [3:0] wr_n, input logic [6:0] d,
                            input logic [1:0] a);
        exp_t e;
        e.wr_n = wr_n;
        e.d    = d;
        e.a    = a;
        exp_q.push_back(e);
    endtask

    // Blank sweep after reset when the clear-on-reset option is built in.
    task automatic push_sweep();
        logic [3:0] p;
        for (int i = 0; i < 16; i++) begin
            p = 4'(i);
            push_exp(~(4'b0001 << p[3:2]), 7'h20, ~p[1:0]);
        end
    endtask

    task automatic do_write(input logic [3:0] pos, input logic [6:0] ch);
        @(negedge CLK_i);
        check("in_ready_before_write", int'(in_ready), 1);
        in_valid = 1'b1;
        in_pos   = pos;
        in_char  = ch;
        @(negedge CLK_i);
        in_valid = 1'b0;
        check("busy_after_accept", int'(busy), 1);
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while ((busy || exp_q.size() != 0) && cyc < 400) begin
            @(negedge CLK_i);
            cyc++;
        end
        check({name, "_idle_wait"}, int'(cyc < 400), 1);
        repeat (3) @(negedge CLK_i);
    endtask

    task automatic wait_strobe(input string name);
        int cyc;
        cyc = 0;
        while (HPDL_WR_n == 4'hF && cyc < 400) begin
            @(negedge CLK_i);
            cyc++;
        end
        check({name, "_strobe_wait"}, int'(cyc < 400), 1);
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin : p_monitor
        logic [3:0] prev_wr;
        logic [6:0] prev_d;
        logic [1:0] prev_a;
        logic       active;
        logic       stable;
        int         plen;
        logic [3:0] cap_wr;
        logic [6:0] cap_d;
        logic [1:0] cap_a;
        exp_t       e;
        prev_wr = 4'hF;
        prev_d  = 7'd0;
        prev_a  = 2'd0;
        active  = 1'b0;
        stable  = 1'b1;
        plen    = 0;
        cap_wr  = 4'hF;
        cap_d   = 7'd0;
        cap_a   = 2'd0;
        forever begin
            @(negedge CLK_i);
            if (RST_i) begin
                active  = 1'b0;
                prev_wr = 4'hF;
            end else begin
                if (!active && HPDL_WR_n != 4'hF) begin
                    active = 1'b1;
                    stable = 1'b1;
                    plen   = 1;
                    cap_wr = HPDL_WR_n;
                    cap_d  = HPDL_D;
                    cap_a  = HPDL_A;
                    check("one_strobe_low", $countones(~HPDL_WR_n), 1);
                    check("setup_d_stable", int'(prev_d), int'(HPDL_D));
                    check("setup_a_stable", int'(prev_a), int'(HPDL_A));
                    check("strobe_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("strobe_wr_n", int'(HPDL_WR_n), int'(e.wr_n));
                        check("strobe_d",    int'(HPDL_D),    int'(e.d));
                        check("strobe_a",    int'(HPDL_A),    int'(e.a));
                    end
                end else if (active && HPDL_WR_n != 4'hF) begin
                    plen++;
                    if (HPDL_WR_n != cap_wr || HPDL_D != cap_d || HPDL_A != cap_a)
                        stable = 1'b0;
                end else if (active) begin
                    active = 1'b0;
                    check("pulse_width",     plen, c_PULSE);
                    check("pulse_da_stable", int'(stable), 1);
                    check("hold_d",          int'(HPDL_D), int'(cap_d));
                    check("hold_a",          int'(HPDL_A), int'(cap_a));
                end
                prev_wr = HPDL_WR_n;
                prev_d  = HPDL_D;
                prev_a  = HPDL_A;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : p_stim
        int bad_wr;
        int bad_busy;

        // Reset values
        repeat (2) @(negedge CLK_i);
        check("rst_in_ready", int'(in_ready),  0);
        check("rst_wr_n",     int'(HPDL_WR_n), 4'hF);
        check("rst_busy",     int'(busy),      0);
        check("rst_d",        int'(HPDL_D),    0);
        check("rst_a",        int'(HPDL_A),    0);
`ifdef HPDL1414_CLEAR_ON_RESET_EN
        push_sweep();
`endif
        RST_i = 1'b0;
        @(negedge CLK_i);
        check("in_ready_after_release", int'(in_ready), 1);
`ifdef HPDL1414_CLEAR_ON_RESET_EN
        wait_idle("clear_sweep");
`else
        bad_wr   = 0;
        bad_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK_i);
            if (HPDL_WR_n != 4'hF) bad_wr++;
            if (busy) bad_busy++;
        end
        check("idle_no_strobe_cycles", bad_wr,   0);
        check("idle_busy_cycles",      bad_busy, 0);
`endif

        // Directed single writes: {pos, char} -> {WR_n, D, A}
        push_exp(4'b1110, 7'h41, 2'b11); do_write(4'd0,  7'h41); wait_idle("pos0_A");
        push_exp(4'b0111, 7'h42, 2'b10); do_write(4'd13, 7'h62); wait_idle("pos13_b");
        push_exp(4'b1101, 7'h20, 2'b01); do_write(4'd6,  7'h05); wait_idle("pos6_ctrl");
        push_exp(4'b1101, 7'h5F, 2'b01); do_write(4'd6,  7'h7F); wait_idle("pos6_7f");
        push_exp(4'b0111, 7'h40, 2'b00); do_write(4'd15, 7'h60); wait_idle("pos15_60");
        push_exp(4'b1101, 7'h20, 2'b11); do_write(4'd4,  7'h1F); wait_idle("pos4_1f");
        push_exp(4'b1110, 7'h5F, 2'b00); do_write(4'd3,  7'h5F); wait_idle("pos3_5f");
        push_exp(4'b1011, 7'h20, 2'b11); do_write(4'd8,  7'h20); wait_idle("pos8_20");
        push_exp(4'b1011, 7'h5A, 2'b00); do_write(4'd11, 7'h7A); wait_idle("pos11_z");

        // Rewrite of pos 9 while its strobe is low: a second sequence follows
        push_exp(4'b1011, 7'h31, 2'b10);
        push_exp(4'b1011, 7'h32, 2'b10);
        do_write(4'd9, 7'h31);
        wait_strobe("pos9_first");
        in_valid = 1'b1;
        in_pos   = 4'd9;
        in_char  = 7'h32;
        @(negedge CLK_i);
        in_valid = 1'b0;
        check("busy_during_rewrite", int'(busy), 1);
        wait_idle("pos9_rewrite");

        // Reset while WR_n is low, with another position pending
        push_exp(4'b1110, 7'h43, 2'b01);
        do_write(4'd2, 7'h43);
        wait_strobe("pos2_reset");
        in_valid = 1'b1;
        in_pos   = 4'd10;
        in_char  = 7'h44;
        @(negedge CLK_i);
        in_valid = 1'b0;
        check("wr_low_before_reset", int'(HPDL_WR_n != 4'hF), 1);
        #1 RST_i = 1'b1;
        #1;
        check("async_reset_wr_n",     int'(HPDL_WR_n), 4'hF);
        check("async_reset_busy",     int'(busy),      0);
        check("async_reset_in_ready", int'(in_ready),  0);
        repeat (2) @(negedge CLK_i);
`ifdef HPDL1414_CLEAR_ON_RESET_EN
        push_sweep();
`endif
        RST_i = 1'b0;
        @(negedge CLK_i);
        check("in_ready_after_rerelease", int'(in_ready), 1);
`ifdef HPDL1414_CLEAR_ON_RESET_EN
        wait_idle("clear_sweep2");
`else
        bad_wr = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK_i);
            if (HPDL_WR_n != 4'hF) bad_wr++;
        end
        check("no_strobe_after_reset", bad_wr, 0);
        check("busy_after_reset",      int'(busy), 0);
`endif

        check("queue_empty_at_end", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/hpdl1414_writer.md
# hpdl1414_writer

Display-side write sequencer for the four-digit HPDL1414 array (4 displays × 4 characters = 16 positions). Accepts character-at-position writes from the UART command stage and holds them in a 16-entry shadow buffer with per-position dirty bits. A scan FSM drives the HPDL data, address and per-display active-low write strobes with programmable setup, pulse and hold timing. It sits directly downstream of the UART receive/command decoder and directly drives the D0–D6, A0–A1 and WR1–WR4 pins.

## Interface

- SETUP_CYC, 1, cycles data/address stable before WR falls (≥1)
- PULSE_CYC, 2, cycles WR held low (≥1)
- HOLD_CYC, 1, cycles data/address held after WR rises (≥1)
- CLK_i  in  1  system clock (12 MHz)
- RST_i  in  1  reset, asynchronous, active-high
- in_valid  in  1  character write request
- in_ready  out  1  write accepted when in_valid & in_ready
- in_pos  in  4  position 0–15; 0 = leftmost character, 15 = rightmost
- in_char  in  7  ASCII code
- HPDL_D  out  7  character data to all displays
- HPDL_A  out  2  digit address (A1,A0)
- HPDL_WR_n  out  4  active-low write strobes, bit k = display k
- busy  out  1  high while any dirty bit is set or a write sequence is in flight

## Operation

- Reset values: HPDL_D=0, HPDL_A=0, HPDL_WR_n=4'b1111, in_ready=0, busy=0; buffer = 0x20 ×16; dirty = 0; scan pointer = 0; FSM = IDLE. in_ready rises the first cycle after RST_i deasserts and then stays high.
- Character folding on accept: 0x20–0x5F are stored unchanged; 0x60–0x7F are stored as code−0x20 (lowercase to uppercase); 0x00–0x1F are stored as 0x20.
- An accepted write stores the folded char at buffer[in_pos] and sets dirty[in_pos]. A repeated write to a position overwrites it; only the last value is displayed.
- Mapping: display = pos[3:2] selects HPDL_WR_n bit; HPDL_A = ~pos[1:0] (the HPDL digit 3 is leftmost).
- FSM states:
  - IDLE: each cycle tests dirty[scan]. If set, latch the buffer char into HPDL_D, drive HPDL_A, clear dirty[scan], and go to SETUP. If clear, scan increments mod 16.
  - SETUP: SETUP_CYC cycles, then assert WR_n[display] low and go to PULSE.
  - PULSE: PULSE_CYC cycles, then deassert WR_n and go to HOLD.
  - HOLD: HOLD_CYC cycles; HPDL_D and HPDL_A stay unchanged. Then scan increments mod 16 and the FSM returns to IDLE.
- Simultaneous dirty clear (IDLE latch) and input write to the same position: the set wins, so the position is rewritten with the new char on a later pass.
- A write to the position currently in SETUP/PULSE/HOLD does not disturb HPDL_D. The dirty bit re-sets and the position is rewritten later.
- At most one WR_n bit is low at any time. HPDL_D and HPDL_A never change while any WR_n is low.
- RST_i mid-sequence forces WR_n high immediately (asynchronously). All state returns to reset values, and pending dirty writes are discarded.

## Timing

- All outputs are registered. No combinational path from input to output, except that in_ready is a register.
- Accept to WR fall, when scan already points at the position and the FSM is idle: 1 (accept) + 1 (IDLE latch) + SETUP_CYC cycles.
- One write sequence occupies 1 + SETUP_CYC + PULSE_CYC + HOLD_CYC cycles. With defaults this is 5 cycles = 417 ns at 12 MHz.
- Worst-case wait for service: 16 positions × 5 cycles + 15 idle scan cycles.
- busy falls the cycle after HOLD ends if no dirty bit remains.

## Configuration

- HPDL1414_CLEAR_ON_RESET_EN
  - Defined: after reset all 16 dirty bits are set, so the FSM writes 0x20 to every position (blanks the displays) before servicing input writes in scan order. busy is high during this sweep.
  - Undefined: dirty resets to 0 and nothing is written until the first input.

## Structure

- Shared package hpdl1414_pkg holds:
  - the FSM state enum (IDLE/SETUP/PULSE/HOLD)
  - constants NUM_POS=16, NUM_DISP=4, CHAR_BLANK=7'h20
  - the char-fold function
- One natural sub-module, hpdl1414_phase_timer: a down-counter loaded with SETUP_CYC/PULSE_CYC/HOLD_CYC that signals phase done. The buffer, dirty bits and FSM stay in the top block.

## Test plan

- Reset release, macro undefined: WR_n stays 4'b1111 for 100 cycles, busy=0, in_ready=1 from the cycle after release.
- Write pos=0, char 0x41: HPDL_A=2'b11, HPDL_D=0x41, WR_n=4'b1110 low for exactly 2 cycles, D/A stable 1 cycle before and after.
- Write pos=13, char 0x62 ('b'): HPDL_D=0x42, HPDL_A=2'b10, WR_n=4'b0111.
- Writes 0x05 then 0x7F to pos 6: the final displayed code is 0x20, then 0x5F. A back-to-back write to the same position during PULSE triggers a second sequence with the new char.
- Macro defined: 16 sequences occur after reset, all with HPDL_D=0x20, covering each WR_n bit 4 times and each address once per display. busy drops after the last HOLD.
- Assert RST_i while WR_n is low: WR_n returns to 4'b1111 within the same cycle, and no further strobes occur after release (macro undefined).
